// File: rtl/yif_pkg.sv
// Shared constants and the fetch-entry record for the yIF prefetch unit.
package yif_pkg;

  localparam int XLEN    = 32;
  localparam int INSN_W  = 32;
  localparam int PC_STEP = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'd128;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [INSN_W-1:0] ins;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/yif_queue.sv
// Registered FIFO of fetch entries. A pushed entry is visible at the head on the
// following cycle; push and pop may coincide at any fill level, including full.
module yif_queue
  import yif_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign do_pop     = pop && head_valid;

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here uses <= so all updates see the pre-edge values,
    // which is what makes a simultaneous push+pop on a full queue safe.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; an entry is only ever read after
    // it has been written, and count/head_valid already come up empty.
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Upstream credit accounting must never push into a full queue without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !do_pop && count == FULL));

endmodule

// File: rtl/yif_prefetch.sv
// Instruction prefetch unit: owns the PC, issues word fetches to a fixed-latency
// imem under a credit limit, tracks them in a delay line and queues the returned
// instructions for decode. A redirect flushes everything and restarts fetch.
module yif_prefetch
  import yif_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int              QUEUE_DEPTH = 4,
  parameter int              IMEM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_ins,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pcp4
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [INSN_W-1:0] ins;
    logic [XLEN-1:0]   pc;
  } entry_t;

  logic [XLEN-1:0]  fetch_pc;
  logic [IMEM_LAT-1:0] dl_valid;
  logic [XLEN-1:0]  dl_pc [IMEM_LAT];
  logic [CNT_W-1:0] q_count;
  logic             q_valid;
  entry_t           q_head;
  entry_t           push_data;
  logic             push;
  int               occupancy;
  logic             redirect_lsb_unused;

  // Queue entries plus requests still in flight bound how much more we may fetch.
  assign occupancy = int'(q_count) + $countones(dl_valid);
  assign imem_req  = rst_n && (occupancy < QUEUE_DEPTH) && !redirect_valid;
  assign imem_addr = fetch_pc;

  // Data returning from imem is paired with the PC that left the delay line.
  assign push      = dl_valid[IMEM_LAT-1] && !redirect_valid;
  assign push_data = '{ins: imem_rdata, pc: dl_pc[IMEM_LAT-1]};

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // PC register and request delay line; a redirect discards every fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      dl_valid <= '0;
      for (int i = 0; i < IMEM_LAT; i++) dl_pc[i] <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      dl_valid <= '0;
    end else begin
      if (imem_req) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      dl_valid[0] <= imem_req;
      dl_pc[0]    <= fetch_pc;
      for (int i = 1; i < IMEM_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_pc[i]    <= dl_pc[i-1];
      end
    end
  end

  yif_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_data),
    .pop        (out_ready),
    .head_valid (q_valid),
    .head       (q_head),
    .count      (q_count)
  );

  // Head presentation; data reads as zero while the queue is empty.
  assign out_valid = q_valid;
  assign out_ins   = q_valid ? q_head.ins : '0;
  assign out_pc    = q_valid ? q_head.pc : '0;
  assign out_pcp4  = q_valid ? q_head.pc + XLEN'(PC_STEP) : '0;

endmodule

// File: tb/tb_yif_prefetch.sv
// Directed bench for yif_prefetch: table-driven cycle vectors on a LAT=1 instance
// plus hand sequences for async reset and back-to-back redirects on a LAT=3 one.
module tb_yif_prefetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_ins, out_pc, out_pcp4;

  logic        r3_valid, ready3;
  logic [31:0] r3_pc;
  logic        imem_req3, out_valid3;
  logic [31:0] imem_addr3, imem_rdata3, out_ins3, out_pc3, out_pcp43;

  int n_checks = 0;
  int n_errors = 0;

  yif_prefetch #(.XLEN(32), .RESET_PC(32'd128), .QUEUE_DEPTH(4), .IMEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_pc(out_pc), .out_pcp4(out_pcp4)
  );

  yif_prefetch #(.XLEN(32), .RESET_PC(32'd128), .QUEUE_DEPTH(4), .IMEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(r3_valid), .redirect_pc(r3_pc),
    .imem_req(imem_req3), .imem_addr(imem_addr3), .imem_rdata(imem_rdata3),
    .out_valid(out_valid3), .out_ready(ready3),
    .out_ins(out_ins3), .out_pc(out_pc3), .out_pcp4(out_pcp43)
  );

  // Fixed-latency imem models: data = address ^ KEY, LAT cycles after the address.
  logic [31:0] a1_q;
  logic [31:0] a3_q [3];
  always @(posedge clk) begin
    a1_q    <= imem_addr;
    a3_q[0] <= imem_addr3;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign imem_rdata  = a1_q ^ KEY;
  assign imem_rdata3 = a3_q[2] ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic ready,
                              input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.ready = ready;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one row's inputs, compare at the falling edge, move past the next rising edge.
  task automatic apply_row(input string tag, input int idx, input vec_t v);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    out_ready      = v.ready;
    @(negedge clk);
    check($sformatf("%s[%0d] imem_req", tag, idx), 32'(imem_req), 32'(v.req));
    check($sformatf("%s[%0d] imem_addr", tag, idx), imem_addr, v.addr);
    check($sformatf("%s[%0d] out_valid", tag, idx), 32'(out_valid), 32'(v.valid));
    if (v.valid) begin
      check($sformatf("%s[%0d] out_pc", tag, idx), out_pc, v.pc);
      check($sformatf("%s[%0d] out_ins", tag, idx), out_ins, v.pc ^ KEY);
      check($sformatf("%s[%0d] out_pcp4", tag, idx), out_pcp4, v.pc + 32'd4);
    end
    tick();
  endtask

  // Hold reset across an edge, check the reset state, release after a rising edge.
  task automatic do_reset(input string tag);
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    rst_n          = 1'b0;
    @(negedge clk);
    check({tag, " rst imem_req"}, 32'(imem_req), 32'd0);
    check({tag, " rst imem_addr"}, imem_addr, 32'd128);
    check({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " rst out_ins"}, out_ins, 32'd0);
    check({tag, " rst out_pc"}, out_pc, 32'd0);
    check({tag, " rst out_pcp4"}, out_pcp4, 32'd0);
    check({tag, " rst lat3 req"}, 32'(imem_req3), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  vec_t tab_stall [16];
  vec_t tab_redir [14];

  initial begin
    logic [31:0] exp_pc;
    int          seen;

    // Stall from reset, then drain: four requests fill the queue, then fetch resumes at 144.
    tab_stall[0] = mk(0, 0, 0, 1, 128, 0, 0);
    tab_stall[1] = mk(0, 0, 0, 1, 132, 0, 0);
    tab_stall[2] = mk(0, 0, 0, 1, 136, 1, 128);
    tab_stall[3] = mk(0, 0, 0, 1, 140, 1, 128);
    for (int i = 4; i < 10; i++) tab_stall[i] = mk(0, 0, 0, 0, 144, 1, 128);
    tab_stall[10] = mk(0, 0, 1, 0, 144, 1, 128);
    tab_stall[11] = mk(0, 0, 1, 1, 144, 1, 132);
    tab_stall[12] = mk(0, 0, 1, 1, 148, 1, 136);
    tab_stall[13] = mk(0, 0, 1, 1, 152, 1, 140);
    tab_stall[14] = mk(0, 0, 1, 1, 156, 1, 144);
    tab_stall[15] = mk(0, 0, 1, 1, 160, 1, 148);

    // Redirect to 0x203 with queued and in-flight work, then redirect across the wrap.
    tab_redir[0]  = mk(0, 0, 0, 1, 128, 0, 0);
    tab_redir[1]  = mk(0, 0, 0, 1, 132, 0, 0);
    tab_redir[2]  = mk(0, 0, 0, 1, 136, 1, 128);
    tab_redir[3]  = mk(1, 32'h203, 0, 0, 140, 1, 128);
    tab_redir[4]  = mk(0, 0, 1, 1, 32'h200, 0, 0);
    tab_redir[5]  = mk(0, 0, 1, 1, 32'h204, 0, 0);
    tab_redir[6]  = mk(0, 0, 1, 1, 32'h208, 1, 32'h200);
    tab_redir[7]  = mk(0, 0, 1, 1, 32'h20C, 1, 32'h204);
    tab_redir[8]  = mk(1, 32'hFFFF_FFF8, 1, 0, 32'h210, 1, 32'h208);
    tab_redir[9]  = mk(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0);
    tab_redir[10] = mk(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    tab_redir[11] = mk(0, 0, 1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
    tab_redir[12] = mk(0, 0, 1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
    tab_redir[13] = mk(0, 0, 1, 1, 32'h0000_0008, 1, 32'h0000_0000);

    redirect_pc = '0;
    r3_valid    = 1'b0;
    r3_pc       = '0;
    ready3      = 1'b1;

    @(posedge clk);
    #1;
    do_reset("stall");
    for (int i = 0; i < 16; i++) apply_row("stall", i, tab_stall[i]);

    do_reset("redir");
    for (int i = 0; i < 14; i++) apply_row("redir", i, tab_redir[i]);

    // Fill the queue, then pull reset between clock edges.
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    repeat (5) tick();
    check("midrst pre out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst imem_req", 32'(imem_req), 32'd0);
    check("midrst imem_addr", imem_addr, 32'd128);
    check("midrst lat3 out_valid", 32'(out_valid3), 32'd0);
    tick();
    rst_n = 1'b1;
    apply_row("post", 0, mk(0, 0, 0, 1, 128, 0, 0));
    apply_row("post", 1, mk(0, 0, 0, 1, 132, 0, 0));
    apply_row("post", 2, mk(0, 0, 0, 1, 136, 1, 128));

    // LAT=3: two consecutive redirects, only the 0x800 stream may ever appear.
    repeat (5) tick();
    r3_valid = 1'b1;
    r3_pc    = 32'h400;
    @(negedge clk);
    check("lat3 redir1 imem_req", 32'(imem_req3), 32'd0);
    tick();
    r3_pc = 32'h800;
    @(negedge clk);
    check("lat3 redir2 imem_req", 32'(imem_req3), 32'd0);
    check("lat3 redir2 out_valid", 32'(out_valid3), 32'd0);
    tick();
    r3_valid = 1'b0;
    r3_pc    = '0;
    @(negedge clk);
    check("lat3 first imem_req", 32'(imem_req3), 32'd1);
    check("lat3 first imem_addr", imem_addr3, 32'h800);
    exp_pc = 32'h800;
    seen   = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 4) check($sformatf("lat3 quiet[%0d]", k), 32'(out_valid3), 32'd0);
      if (k == 4) check("lat3 first out_valid", 32'(out_valid3), 32'd1);
      if (out_valid3) begin
        check($sformatf("lat3 out_pc[%0d]", seen), out_pc3, exp_pc);
        check($sformatf("lat3 out_ins[%0d]", seen), out_ins3, exp_pc ^ KEY);
        exp_pc = exp_pc + 32'd4;
        seen++;
      end
      @(negedge clk);
    end
    check("lat3 progress", 32'(seen > 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
